// File: rtl/mac_array_ctrl.sv
// Pass sequencer for the MAC column array: loads weight rows, waits for the load token
// to clear the column chain, streams activation vectors, then drains the last column.
module mac_array_ctrl #(
   parameter int unsigned Col     = 8,
   parameter int unsigned LoadCyc = 8,
   parameter int unsigned Gap     = 9,
   parameter int unsigned CntBw   = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [CntBw-1:0] num_vec_i,
   input  logic             cfg_reconfigure_i,
   input  logic             cfg_is_signed_i,
   input  logic             l0_empty_i,
   output logic             l0_rd_o,
   output logic [1:0]       inst_o,
   output logic             reconfigure_o,
   output logic             is_signed_o,
   input  logic [Col-1:0]   fifo_wr_i,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned LdW = $clog2(LoadCyc + 1);
   localparam int unsigned GpW = $clog2(Gap + 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StGap,
      StExec,
      StDrain,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [LdW-1:0]   load_cnt_q, load_cnt_d;
   logic [GpW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [CntBw-1:0] vec_cnt_q, vec_cnt_d;
   logic [CntBw-1:0] out_cnt_q, out_cnt_d;
   logic [CntBw-1:0] num_vec_q, num_vec_d;
   logic             reconfigure_q, reconfigure_d;
   logic             is_signed_q, is_signed_d;
   logic [1:0]       inst_q, inst_d;
   logic             load_rd, exec_rd;
   logic             last_wr;
   logic             unused_fifo_wr;

   // Only the last column's strobe marks a finished psum.
   assign last_wr        = fifo_wr_i[Col-1];
   assign unused_fifo_wr = ^fifo_wr_i[Col-2:0];

   always_comb begin
      state_d       = state_q;
      load_cnt_d    = load_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      vec_cnt_d     = vec_cnt_q;
      out_cnt_d     = out_cnt_q;
      num_vec_d     = num_vec_q;
      reconfigure_d = reconfigure_q;
      is_signed_d   = is_signed_q;
      load_rd       = 1'b0;
      exec_rd       = 1'b0;
      busy_o        = 1'b0;
      done_o        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               num_vec_d     = num_vec_i;
               reconfigure_d = cfg_reconfigure_i;
               is_signed_d   = cfg_is_signed_i;
               load_cnt_d    = '0;
               gap_cnt_d     = '0;
               vec_cnt_d     = '0;
               out_cnt_d     = '0;
               state_d       = StLoad;
            end
         end
         StLoad: begin
            busy_o  = 1'b1;
            load_rd = !l0_empty_i;
            if (load_rd) begin
               load_cnt_d = load_cnt_q + LdW'(1);
               if (load_cnt_q == LdW'(LoadCyc - 1)) begin
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            busy_o    = 1'b1;
            gap_cnt_d = gap_cnt_q + GpW'(1);
            if (gap_cnt_q == GpW'(Gap - 1)) begin
               state_d = (num_vec_q == '0) ? StDone : StExec;
            end
         end
         StExec: begin
            busy_o    = 1'b1;
            exec_rd   = !l0_empty_i;
            out_cnt_d = out_cnt_q + CntBw'(last_wr);
            if (exec_rd) begin
               vec_cnt_d = vec_cnt_q + CntBw'(1);
               if (vec_cnt_d == num_vec_q) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            busy_o    = 1'b1;
            out_cnt_d = out_cnt_q + CntBw'(last_wr);
            // Looking at the next count lets done follow the final psum by one cycle.
            if (out_cnt_d >= num_vec_q) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      inst_d = {exec_rd, load_rd};
   end

   // A read issued in the reset cycle would be lost, so suppress it.
   assign l0_rd_o       = (load_rd | exec_rd) & ~reset_i;
   assign inst_o        = inst_q;
   assign reconfigure_o = reconfigure_q;
   assign is_signed_o   = is_signed_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         load_cnt_q    <= '0;
         gap_cnt_q     <= '0;
         vec_cnt_q     <= '0;
         out_cnt_q     <= '0;
         num_vec_q     <= '0;
         reconfigure_q <= 1'b0;
         is_signed_q   <= 1'b0;
         inst_q        <= 2'b00;
      end else begin
         state_q       <= state_d;
         load_cnt_q    <= load_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         vec_cnt_q     <= vec_cnt_d;
         out_cnt_q     <= out_cnt_d;
         num_vec_q     <= num_vec_d;
         reconfigure_q <= reconfigure_d;
         is_signed_q   <= is_signed_d;
         inst_q        <= inst_d;
      end
   end

endmodule
